// File: rtl/misc_issue_sched.sv
// misc_issue_sched
//   Lets two requesters share one fixed-latency miscellaneous unit
//   (DAA/DAS/NEG/BSWAP/RND/POS/FP2INT/INT2FP).
//   - Round-robin arbitration. Each accepted op is registered and presented
//     to the unit for exactly one ACT cycle.
//   - A LATENCY-deep tag pipe carries {valid, requester ID, DST} alongside
//     the unit.
//   - Returning results are written into a DEPTH-entry FIFO. A credit counter
//     (OCC) bounds the number of ops in flight, so the FIFO can never
//     overflow and backpressure never drops a result.
// Ports
//   CLK, RESET                    clock, synchronous active-high reset
//   REQ_VALID/REQ_READY [1:0]     per-requester handshake
//   REQ_OP/SA/SB/SD/DST/A/B/CIN   packed {r1,r0} operands
//   ACT, OpCODE, SA, SB, SD,
//   DSTi, CIN, A, B               registered issue to the unit
//   U_R, U_FLAGS                  unit result, valid LATENCY cycles after ACT
//   RES_VALID/RES_READY           result FIFO head handshake
//   RES_ID, RES_DST, RES_R,
//   RES_FLAGS                     result FIFO head contents
module misc_issue_sched #(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [1:0]   REQ_VALID,
  output logic [1:0]   REQ_READY,
  input  logic [5:0]   REQ_OP,
  input  logic [5:0]   REQ_SA,
  input  logic [5:0]   REQ_SB,
  input  logic [5:0]   REQ_SD,
  input  logic [9:0]   REQ_DST,
  input  logic [255:0] REQ_A,
  input  logic [31:0]  REQ_B,
  input  logic [31:0]  REQ_CIN,
  output logic         ACT,
  output logic [2:0]   OpCODE,
  output logic [2:0]   SA,
  output logic [2:0]   SB,
  output logic [2:0]   SD,
  output logic [4:0]   DSTi,
  output logic [15:0]  CIN,
  output logic [127:0] A,
  output logic [15:0]  B,
  input  logic [127:0] U_R,
  input  logic [7:0]   U_FLAGS,
  output logic         RES_VALID,
  input  logic         RES_READY,
  output logic         RES_ID,
  output logic [4:0]   RES_DST,
  output logic [127:0] RES_R,
  output logic [7:0]   RES_FLAGS
);

  localparam int OW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // ---------------- arbitration / credits ----------------
  logic [OW-1:0] occ_reg;
  logic          last_reg;
  logic [1:0]    grant;
  logic          credit_ok;
  logic          accept;
  logic          sel;
  logic          pop;

  always_comb begin
    grant = 2'b00;
    case (REQ_VALID)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_reg ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // The registered count is used on purpose. A pop in this cycle only frees
  // its credit on the next cycle, which keeps the ready path short.
  // Ready is also held low while reset is asserted.
  assign credit_ok = (occ_reg < OW'(DEPTH)) && !RESET;
  assign REQ_READY = credit_ok ? grant : 2'b00;
  assign accept    = |REQ_READY;
  assign sel       = REQ_READY[1];
  assign pop       = RES_VALID && RES_READY;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      occ_reg  <= '0;
      last_reg <= 1'b1;
    end else begin
      if (accept && !pop)
        occ_reg <= occ_reg + 1'b1;
      else if (!accept && pop)
        occ_reg <= occ_reg - 1'b1;
      if (accept)
        last_reg <= sel;
    end
  end

  // ---------------- issue register ----------------
  logic id_reg;

  always_ff @(posedge CLK) begin
    if (RESET)
      ACT <= 1'b0;
    else
      ACT <= accept;
    if (accept) begin
      id_reg <= sel;
      OpCODE <= sel ? REQ_OP[5:3]      : REQ_OP[2:0];
      SA     <= sel ? REQ_SA[5:3]      : REQ_SA[2:0];
      SB     <= sel ? REQ_SB[5:3]      : REQ_SB[2:0];
      SD     <= sel ? REQ_SD[5:3]      : REQ_SD[2:0];
      DSTi   <= sel ? REQ_DST[9:5]     : REQ_DST[4:0];
      A      <= sel ? REQ_A[255:128]   : REQ_A[127:0];
      B      <= sel ? REQ_B[31:16]     : REQ_B[15:0];
      CIN    <= sel ? REQ_CIN[31:16]   : REQ_CIN[15:0];
    end
  end

  // ---------------- tag pipe ----------------
  // The tag pipe runs alongside the unit pipeline. The unit's own DSTo is not
  // trusted; only these tags decide what is written into the FIFO.
  logic       vld_pipe [LATENCY];
  logic       id_pipe  [LATENCY];
  logic [4:0] dst_pipe [LATENCY];

  always_ff @(posedge CLK) begin
    for (int i = 0; i < LATENCY; i++) begin
      if (RESET)
        vld_pipe[i] <= 1'b0;
      else
        vld_pipe[i] <= (i == 0) ? ACT : vld_pipe[(i == 0) ? 0 : i - 1];
      id_pipe[i]  <= (i == 0) ? id_reg : id_pipe[(i == 0) ? 0 : i - 1];
      dst_pipe[i] <= (i == 0) ? DSTi   : dst_pipe[(i == 0) ? 0 : i - 1];
    end
  end

  // ---------------- result FIFO ----------------
  logic [127:0]  mem_r   [DEPTH];
  logic [7:0]    mem_f   [DEPTH];
  logic [4:0]    mem_dst [DEPTH];
  logic          mem_id  [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [OW-1:0] cnt_reg;
  logic          wr_en;

  assign wr_en = vld_pipe[LATENCY-1];

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem_r[wr_ptr_reg]   <= U_R;
      mem_f[wr_ptr_reg]   <= U_FLAGS;
      mem_dst[wr_ptr_reg] <= dst_pipe[LATENCY-1];
      mem_id[wr_ptr_reg]  <= id_pipe[LATENCY-1];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      if (wr_en)
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      cnt_reg <= cnt_reg + OW'(wr_en) - OW'(pop);
    end
  end

  assign RES_VALID = (cnt_reg != '0);
  assign RES_ID    = mem_id[rd_ptr_reg];
  assign RES_DST   = mem_dst[rd_ptr_reg];
  assign RES_R     = mem_r[rd_ptr_reg];
  assign RES_FLAGS = mem_f[rd_ptr_reg];

endmodule

// File: tb/tb_misc_issue_sched.sv
// tb_misc_issue_sched
//   Drives directed vectors into misc_issue_sched and models the shared unit
//   as a two-stage pipeline.
//   - Expected results are queued when an op is accepted, then popped and
//     compared as results leave the FIFO.
//   - Grant order, accept cycles and result cycles are checked against
//     hand-derived sequences.
module tb_misc_issue_sched;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [1:0]   REQ_VALID;
  logic [1:0]   REQ_READY;
  logic [5:0]   REQ_OP, REQ_SA, REQ_SB, REQ_SD;
  logic [9:0]   REQ_DST;
  logic [255:0] REQ_A;
  logic [31:0]  REQ_B, REQ_CIN;
  logic         ACT;
  logic [2:0]   OpCODE, SA, SB, SD;
  logic [4:0]   DSTi;
  logic [15:0]  CIN;
  logic [127:0] A;
  logic [15:0]  B;
  logic [127:0] U_R;
  logic [7:0]   U_FLAGS;
  logic         RES_VALID, RES_READY, RES_ID;
  logic [4:0]   RES_DST;
  logic [127:0] RES_R;
  logic [7:0]   RES_FLAGS;

  misc_issue_sched #(.LATENCY(2), .DEPTH(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_OP(REQ_OP), .REQ_SA(REQ_SA), .REQ_SB(REQ_SB), .REQ_SD(REQ_SD),
    .REQ_DST(REQ_DST), .REQ_A(REQ_A), .REQ_B(REQ_B), .REQ_CIN(REQ_CIN),
    .ACT(ACT), .OpCODE(OpCODE), .SA(SA), .SB(SB), .SD(SD),
    .DSTi(DSTi), .CIN(CIN), .A(A), .B(B),
    .U_R(U_R), .U_FLAGS(U_FLAGS),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_ID(RES_ID),
    .RES_DST(RES_DST), .RES_R(RES_R), .RES_FLAGS(RES_FLAGS)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- unit model ----------------
  function automatic logic [127:0] unit_r(input logic [2:0] op, input logic [127:0] a,
                                          input logic [15:0] b, input logic [15:0] cin);
    if (op == 3'd2) return -a;
    return a ^ {96'd0, b, cin} ^ {125'd0, op};
  endfunction

  function automatic logic [7:0] unit_f(input logic [2:0] sa, input logic [2:0] sb,
                                        input logic [2:0] sd, input logic [4:0] dst);
    return {sd, sa[1:0] ^ sb[1:0], dst[2:0]};
  endfunction

  logic [127:0] p0_r, p1_r;
  logic [7:0]   p0_f, p1_f;
  always @(posedge CLK) begin
    if (ACT) begin
      p0_r <= unit_r(OpCODE, A, B, CIN);
      p0_f <= unit_f(SA, SB, SD, DSTi);
    end else begin
      p0_r <= 128'hDEAD_BEEF;
      p0_f <= 8'hEE;
    end
    p1_r <= p0_r;
    p1_f <= p0_f;
  end
  assign U_R     = p1_r;
  assign U_FLAGS = p1_f;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic         id;
    logic [4:0]   dst;
    logic [127:0] r;
    logic [7:0]   f;
  } exp_t;

  exp_t exp_q[$];
  int   acc_id_q[$];
  int   acc_cyc_q[$];
  int   pop_cyc_q[$];
  int   model_occ = 0;

  always @(negedge CLK) begin
    if (RESET) begin
      exp_q.delete();
      model_occ = 0;
    end else begin
      int   occ_before;
      int   i;
      exp_t e;
      occ_before = model_occ;
      chk("ready_not_both", {127'd0, REQ_READY == 2'b11}, 128'd0);
      if (RES_VALID && RES_READY) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result_dst", {123'd0, RES_DST}, 128'hFFFF);
        end else begin
          e = exp_q.pop_front();
          chk("res_tag", {114'd0, RES_ID, RES_DST, RES_FLAGS}, {114'd0, e.id, e.dst, e.f});
          chk("res_r", RES_R, e.r);
        end
        model_occ--;
        pop_cyc_q.push_back(cyc);
      end
      if ((REQ_VALID & REQ_READY) != 2'b00) begin
        i = REQ_READY[1] ? 1 : 0;
        chk("credit_ok", {127'd0, occ_before < 4}, 128'd1);
        e.id  = REQ_READY[1];
        e.dst = REQ_DST[i*5 +: 5];
        e.r   = unit_r(REQ_OP[i*3 +: 3], REQ_A[i*128 +: 128], REQ_B[i*16 +: 16], REQ_CIN[i*16 +: 16]);
        e.f   = unit_f(REQ_SA[i*3 +: 3], REQ_SB[i*3 +: 3], REQ_SD[i*3 +: 3], REQ_DST[i*5 +: 5]);
        exp_q.push_back(e);
        model_occ++;
        acc_id_q.push_back(i);
        acc_cyc_q.push_back(cyc);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [2:0] sa,
                         input logic [2:0] sb, input logic [2:0] sd, input logic [4:0] dst,
                         input logic [127:0] a, input logic [15:0] b, input logic [15:0] cin);
    REQ_OP[i*3 +: 3]    = op;
    REQ_SA[i*3 +: 3]    = sa;
    REQ_SB[i*3 +: 3]    = sb;
    REQ_SD[i*3 +: 3]    = sd;
    REQ_DST[i*5 +: 5]   = dst;
    REQ_A[i*128 +: 128] = a;
    REQ_B[i*16 +: 16]   = b;
    REQ_CIN[i*16 +: 16] = cin;
  endtask

  task automatic do_reset();
    RESET     = 1'b1;
    REQ_VALID = 2'b00;
    tick();
    RESET = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    REQ_VALID = 2'b00;
    RES_READY = 1'b1;
    while ((exp_q.size() != 0 || RES_VALID) && n < 40) begin
      tick();
      n++;
    end
    chk("drain_done", {127'd0, n < 40}, 128'd1);
    tick();
    tick();
  endtask

  int base;
  int pbase;
  int it;
  int rel_acc2[6] = '{0, 1, 2, 3, 5, 6};
  int rel_acc4[8] = '{0, 1, 2, 3, 5, 6, 7, 8};
  int rel_pop4[8] = '{4, 5, 6, 7, 9, 10, 11, 12};

  initial begin
    RESET = 1'b1; REQ_VALID = 2'b00; RES_READY = 1'b1;
    REQ_OP = '0; REQ_SA = '0; REQ_SB = '0; REQ_SD = '0; REQ_DST = '0;
    REQ_A = '0; REQ_B = '0; REQ_CIN = '0;
    tick(); tick(); tick();
    RESET = 1'b0;

    // reset state
    #1;
    chk("rst_act", {127'd0, ACT}, 128'd0);
    chk("rst_res_valid", {127'd0, RES_VALID}, 128'd0);
    chk("rst_ready", {126'd0, REQ_READY}, 128'd0);

    // 1: single NEG op on requester 0
    set_req(0, 3'd2, 3'd0, 3'd0, 3'd3, 5'd7, 128'd5, 16'd0, 16'd0);
    REQ_VALID = 2'b01;
    #1;
    chk("t1_ready", {126'd0, REQ_READY}, 128'd1);
    tick();
    REQ_VALID = 2'b00;
    chk("t1_act", {127'd0, ACT}, 128'd1);
    chk("t1_issue", {115'd0, OpCODE, SD, DSTi, 2'b00}, {115'd0, 3'd2, 3'd3, 5'd7, 2'b00});
    chk("t1_a", A, 128'd5);
    tick();
    chk("t1_act_t2", {127'd0, ACT}, 128'd0);
    chk("t1_rv_t2", {127'd0, RES_VALID}, 128'd0);
    tick();
    chk("t1_rv_t3", {127'd0, RES_VALID}, 128'd0);
    tick();
    chk("t1_rv_t4", {127'd0, RES_VALID}, 128'd1);
    chk("t1_id_dst", {122'd0, RES_ID, RES_DST}, {122'd0, 1'b0, 5'd7});
    chk("t1_r_low", {64'd0, RES_R[63:0]}, {64'd0, 64'hFFFF_FFFF_FFFF_FFFB});
    chk("t1_flags", {120'd0, RES_FLAGS}, 128'h67);
    tick();
    chk("t1_rv_t5", {127'd0, RES_VALID}, 128'd0);
    drain();

    // 2: contention from reset, both requesters always valid
    do_reset();
    base = acc_id_q.size();
    it = 0;
    REQ_VALID = 2'b11;
    while (acc_id_q.size() < base + 6 && it < 20) begin
      set_req(0, 3'(it), 3'd1, 3'd2, 3'd1, 5'(2 * it),     128'(it * 17 + 3), 16'(it), 16'h0101);
      set_req(1, 3'd5,   3'd2, 3'd3, 3'd2, 5'(2 * it + 1), 128'(it * 29 + 9), 16'h00F0, 16'(it));
      tick();
      it++;
    end
    REQ_VALID = 2'b00;
    chk("t2_accepts", acc_id_q.size() - base, 6);
    if (acc_id_q.size() >= base + 6) begin
      for (int j = 0; j < 6; j++) begin
        chk("t2_grant", acc_id_q[base + j], j % 2);
        chk("t2_acc_cycle", acc_cyc_q[base + j] - acc_cyc_q[base], rel_acc2[j]);
      end
    end
    drain();

    // 3: backpressure with RES_READY low
    RES_READY = 1'b0;
    base = acc_id_q.size();
    REQ_VALID = 2'b01;
    for (int k = 0; k < 10; k++) begin
      set_req(0, 3'd3, 3'd4, 3'd1, 3'd2, 5'(k + 16), 128'(1000 + k), 16'(k * 3), 16'h00AA);
      tick();
    end
    #1;
    chk("t3_accepts", acc_id_q.size() - base, 4);
    chk("t3_ready_blocked", {126'd0, REQ_READY}, 128'd0);
    RES_READY = 1'b1;
    #1;
    chk("t3_ready_pop_cycle", {126'd0, REQ_READY}, 128'd0);
    tick();
    RES_READY = 1'b0;
    #1;
    chk("t3_ready_after_pop", {126'd0, REQ_READY}, 128'd1);
    tick();
    chk("t3_ready_refull", {126'd0, REQ_READY}, 128'd0);
    chk("t3_accepts_total", acc_id_q.size() - base, 5);
    drain();

    // 4: throughput, 8 requester-1 ops, limited by the 4 credits
    base  = acc_id_q.size();
    pbase = pop_cyc_q.size();
    it = 0;
    REQ_VALID = 2'b10;
    while (acc_id_q.size() < base + 8 && it < 30) begin
      set_req(1, 3'(it + 1), 3'd3, 3'd5, 3'd4, 5'(it + 8), {64'hA5A5, 64'(it)}, 16'h1234, 16'(it * 7));
      tick();
      it++;
    end
    REQ_VALID = 2'b00;
    drain();
    chk("t4_accepts", acc_id_q.size() - base, 8);
    chk("t4_pops", pop_cyc_q.size() - pbase, 8);
    if (acc_id_q.size() >= base + 8 && pop_cyc_q.size() >= pbase + 8) begin
      for (int j = 0; j < 8; j++) begin
        chk("t4_acc_cycle", acc_cyc_q[base + j] - acc_cyc_q[base], rel_acc4[j]);
        chk("t4_pop_cycle", pop_cyc_q[pbase + j] - acc_cyc_q[base], rel_pop4[j]);
      end
    end

    // 5: reset while three ops are in flight
    base = acc_id_q.size();
    REQ_VALID = 2'b01;
    for (int k = 0; k < 3; k++) begin
      set_req(0, 3'd1, 3'd1, 3'd1, 3'd1, 5'(k + 1), 128'(k + 50), 16'd9, 16'd9);
      tick();
    end
    chk("t5_accepts", acc_id_q.size() - base, 3);
    do_reset();
    for (int k = 0; k < 6; k++) begin
      chk("t5_no_result", {127'd0, RES_VALID}, 128'd0);
      tick();
    end
    pbase = pop_cyc_q.size();
    set_req(0, 3'd2, 3'd0, 3'd1, 3'd3, 5'd21, 128'h77, 16'd0, 16'd0);
    REQ_VALID = 2'b01;
    tick();
    REQ_VALID = 2'b00;
    drain();
    chk("t5_single_result", pop_cyc_q.size() - pbase, 1);

    // 6: FIFO at three entries, fourth write coincides with a pop
    RES_READY = 1'b0;
    REQ_VALID = 2'b01;
    for (int k = 0; k < 3; k++) begin
      set_req(0, 3'd4, 3'd2, 3'd2, 3'd2, 5'(k + 24), 128'(k * 1000 + 1), 16'(k), 16'd3);
      tick();
    end
    REQ_VALID = 2'b00;
    tick(); tick(); tick();
    set_req(0, 3'd6, 3'd1, 3'd0, 3'd5, 5'd30, 128'h4444, 16'd4, 16'd4);
    REQ_VALID = 2'b01;
    #1;
    chk("t6_fourth_ready", {126'd0, REQ_READY}, 128'd1);
    tick();
    set_req(0, 3'd7, 3'd3, 3'd3, 3'd6, 5'd31, 128'h5555, 16'd5, 16'd5);
    #1;
    chk("t6_full_c7", {126'd0, REQ_READY}, 128'd0);
    tick();
    chk("t6_full_c8", {126'd0, REQ_READY}, 128'd0);
    tick();
    RES_READY = 1'b1;
    #1;
    chk("t6_full_c9", {126'd0, REQ_READY}, 128'd0);
    chk("t6_head_valid", {127'd0, RES_VALID}, 128'd1);
    tick();
    RES_READY = 1'b0;
    #1;
    chk("t6_credit_back", {126'd0, REQ_READY}, 128'd1);
    chk("t6_fifo_nonempty", {127'd0, RES_VALID}, 128'd1);
    tick();
    chk("t6_full_again", {126'd0, REQ_READY}, 128'd0);
    drain();

    chk("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
